// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS unified memory port arbiter.
// Struct widths mirror the default top-level parameters.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_prio_pick.sv
// Fixed LS-over-IF priority pick; a starved fetch overrides data priority.
module arb_prio_pick (
    input  logic if_req,
    input  logic ls_req,
    input  logic starved,
    output logic if_pick,
    output logic ls_pick
);

    always_comb begin
        if_pick = 1'b0;
        ls_pick = 1'b0;
        if (ls_req && !(if_req && starved)) begin
            ls_pick = 1'b1;
        end else if (if_req) begin
            if_pick = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and LS onto one memory port, one transaction in flight,
// LS priority with a consecutive-grant limit that guarantees fetch progress.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int MaxDataGrants = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   if_req,
    input  logic [AddrWidth-1:0]   if_addr,
    output logic                   if_gnt,
    output logic                   if_rvalid,
    output logic [DataWidth-1:0]   if_rdata,
    input  logic                   ls_req,
    input  logic                   ls_we,
    input  logic [AddrWidth-1:0]   ls_addr,
    input  logic [DataWidth-1:0]   ls_wdata,
    input  logic [DataWidth/8-1:0] ls_wstrb,
    output logic                   ls_gnt,
    output logic                   ls_rvalid,
    output logic [DataWidth-1:0]   ls_rdata,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [AddrWidth-1:0]   mem_addr,
    output logic [DataWidth-1:0]   mem_wdata,
    output logic [DataWidth/8-1:0] mem_wstrb,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [DataWidth-1:0]   mem_rdata
);

    localparam int StrbWidth = DataWidth / 8;

    arb_state_e           state_q, state_d;
    owner_e               owner_q;
    logic [3:0]           starve_cnt_q;
    logic                 lat_we_q;
    logic [AddrWidth-1:0] lat_addr_q;
    logic [DataWidth-1:0] lat_wdata_q;
    logic [StrbWidth-1:0] lat_wstrb_q;

    logic starved;
    logic pick_if;
    logic pick_ls;

    assign starved = (starve_cnt_q == 4'(MaxDataGrants));

    arb_prio_pick u_pick (
        .if_req  (if_req),
        .ls_req  (ls_req),
        .starved (starved),
        .if_pick (pick_if),
        .ls_pick (pick_ls)
    );

    always_comb begin
        state_d   = state_q;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        case (state_q)
            IDLE: begin
                if_gnt = pick_if;
                ls_gnt = pick_ls;
                if (pick_if || pick_ls) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = lat_we_q;
                mem_addr  = lat_addr_q;
                mem_wdata = lat_wdata_q;
                mem_wstrb = lat_wstrb_q;
                if (mem_gnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (owner_q == OWN_IF) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end else begin
                        ls_rvalid = 1'b1;
                        // Stores are acknowledged with zero data
                        ls_rdata  = lat_we_q ? '0 : mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            starve_cnt_q <= '0;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            lat_wstrb_q  <= '0;
        end else begin
            state_q <= state_d;
            if (if_gnt) begin
                owner_q      <= OWN_IF;
                lat_we_q     <= 1'b0;
                lat_addr_q   <= if_addr;
                lat_wdata_q  <= '0;
                lat_wstrb_q  <= '0;
                starve_cnt_q <= '0;
            end else if (ls_gnt) begin
                owner_q     <= OWN_LS;
                lat_we_q    <= ls_we;
                lat_addr_q  <= ls_addr;
                lat_wdata_q <= ls_wdata;
                lat_wstrb_q <= ls_wstrb;
                // Only LS grants that bypass a waiting fetch count toward starvation
                if (if_req) begin
                    if (!starved) begin
                        starve_cnt_q <= starve_cnt_q + 4'd1;
                    end
                end else begin
                    starve_cnt_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester and memory models drive the DUT,
// expected grants/requests/responses are queued and checked as they appear.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXG = 4;

    typedef struct packed {
        owner_e        own;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic [SW-1:0] ls_wstrb;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [SW-1:0] mem_wstrb;

    mem_arbiter #(
        .AddrWidth     (AW),
        .DataWidth     (DW),
        .MaxDataGrants (MAXG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_wstrb   (ls_wstrb),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    owner_e   exp_gnt[$];
    mem_req_t exp_mem[$];
    rsp_t     exp_rsp[$];

    // Configuration written only by the main sequence
    int            if_total, ls_total, gnt_delay, rv_delay;
    int            spur_idle_tok, spur_req_tok;
    logic [AW-1:0] if_base, ls_base;
    logic [DW-1:0] ls_wbase;
    logic          ls_we_cfg;
    logic [SW-1:0] ls_strb_cfg;
    bit            chk_b2b;

    // State owned by the bus-functional process
    int            cyc, if_done, ls_done, wait_cnt, pend_cnt;
    int            spur_idle_done, spur_req_done;
    int            gnt_cyc, acc_cyc, last_gnt_cyc, b2b_n;
    bit            got_if, got_ls, first_req;
    logic [AW-1:0] pend_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    // Requesters, memory model and monitor
    initial begin
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        cyc = 0; if_done = 0; ls_done = 0; wait_cnt = 0; pend_cnt = 0; pend_addr = '0;
        spur_idle_done = 0; spur_req_done = 0;
        gnt_cyc = 0; acc_cyc = 0; last_gnt_cyc = 0; b2b_n = 0;
        got_if = 1'b0; got_ls = 1'b0; first_req = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (got_if) if_done++;
            if (got_ls) ls_done++;
            got_if = 1'b0;
            got_ls = 1'b0;
            if_req   = (if_done < if_total);
            if_addr  = if_base + 32'(4 * if_done);
            ls_req   = (ls_done < ls_total);
            ls_we    = ls_we_cfg;
            ls_addr  = ls_base + 32'(4 * ls_done);
            ls_wdata = ls_wbase + 32'(ls_done);
            ls_wstrb = ls_strb_cfg;

            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            if (pend_cnt != 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_model(pend_addr);
                end
            end else if (mem_req) begin
                if (spur_req_tok != spur_req_done && wait_cnt == 0 && gnt_delay > 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hBAD0_BAD0;
                    spur_req_done++;
                end
                if (wait_cnt == gnt_delay) begin
                    mem_gnt   = 1'b1;
                    wait_cnt  = 0;
                    pend_cnt  = rv_delay;
                    pend_addr = mem_addr;
                end else begin
                    wait_cnt++;
                end
            end else if (spur_idle_tok != spur_idle_done) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD0_BAD0;
                spur_idle_done++;
            end

            @(negedge clk);
            check_eq("if_rdata_quiet", 64'(if_rvalid ? '0 : if_rdata), 64'(0));
            check_eq("ls_rdata_quiet", 64'(ls_rvalid ? '0 : ls_rdata), 64'(0));
            if (!chk_b2b) b2b_n = 0;

            if (if_gnt || ls_gnt) begin
                check_eq("gnt_onehot", 64'(if_gnt & ls_gnt), 64'(0));
                check_eq("gnt_expected", 64'(exp_gnt.size() != 0), 64'(1));
                if (exp_gnt.size() != 0) begin
                    owner_e eo;
                    eo = exp_gnt.pop_front();
                    check_eq("gnt_owner", 64'(ls_gnt), 64'(eo == OWN_LS));
                end
                if (chk_b2b) begin
                    if (b2b_n > 0) check_eq("gnt_gap", 64'(cyc - last_gnt_cyc), 64'(3));
                    b2b_n++;
                end
                if (if_gnt) begin
                    exp_mem.push_back('{we: 1'b0, addr: if_addr, wdata: '0, wstrb: '0});
                    exp_rsp.push_back('{own: OWN_IF, rdata: rd_model(if_addr)});
                    got_if = 1'b1;
                end else begin
                    exp_mem.push_back('{we: ls_we, addr: ls_addr, wdata: ls_wdata, wstrb: ls_wstrb});
                    exp_rsp.push_back('{own: OWN_LS, rdata: ls_we ? '0 : rd_model(ls_addr)});
                    got_ls = 1'b1;
                end
                gnt_cyc      = cyc;
                last_gnt_cyc = cyc;
                first_req    = 1'b1;
            end

            if (mem_req) begin
                check_eq("mem_req_expected", 64'(exp_mem.size() != 0), 64'(1));
                if (exp_mem.size() != 0) begin
                    check_eq("mem_we", 64'(mem_we), 64'(exp_mem[0].we));
                    check_eq("mem_addr", 64'(mem_addr), 64'(exp_mem[0].addr));
                    check_eq("mem_wdata", 64'(mem_wdata), 64'(exp_mem[0].wdata));
                    check_eq("mem_wstrb", 64'(mem_wstrb), 64'(exp_mem[0].wstrb));
                    if (first_req) check_eq("req_latency", 64'(cyc - gnt_cyc), 64'(1));
                    first_req = 1'b0;
                    if (mem_gnt) begin
                        check_eq("accept_latency", 64'(cyc - gnt_cyc), 64'(1 + gnt_delay));
                        void'(exp_mem.pop_front());
                        acc_cyc = cyc;
                    end
                end
            end

            if (if_rvalid || ls_rvalid) begin
                check_eq("rsp_expected", 64'(exp_rsp.size() != 0), 64'(1));
                if (exp_rsp.size() != 0) begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    check_eq("rsp_owner", 64'({if_rvalid, ls_rvalid}),
                             64'((r.own == OWN_IF) ? 2'b10 : 2'b01));
                    check_eq("rsp_rdata", 64'((r.own == OWN_IF) ? if_rdata : ls_rdata), 64'(r.rdata));
                    check_eq("rsp_latency", 64'(cyc - acc_cyc), 64'(rv_delay));
                end
            end
        end
    end

    task automatic issue_if(input logic [AW-1:0] base, input int n);
        if_base  = base - 32'(4 * if_done);
        if_total = if_done + n;
    endtask

    task automatic issue_ls(input logic [AW-1:0] base, input int n, input logic we,
                            input logic [DW-1:0] wbase, input logic [SW-1:0] strb);
        ls_base     = base - 32'(4 * ls_done);
        ls_wbase    = wbase - 32'(ls_done);
        ls_we_cfg   = we;
        ls_strb_cfg = strb;
        ls_total    = ls_done + n;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (n < 400 && !(if_done == if_total && ls_done == ls_total &&
                            exp_gnt.size() == 0 && exp_mem.size() == 0 && exp_rsp.size() == 0)) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_eq({tag, "_complete"}, 64'(n < 400), 64'(1));
        @(negedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        check_eq({tag, "_ctl"}, 64'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, mem_we}), 64'(0));
        check_eq({tag, "_rdata"}, {if_rdata, ls_rdata}, 64'(0));
        check_eq({tag, "_maddr"}, 64'(mem_addr), 64'(0));
        check_eq({tag, "_mwdata"}, 64'(mem_wdata), 64'(0));
        check_eq({tag, "_mwstrb"}, 64'(mem_wstrb), 64'(0));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        if_total = 0; ls_total = 0; gnt_delay = 0; rv_delay = 1;
        spur_idle_tok = 0; spur_req_tok = 0;
        if_base = '0; ls_base = '0; ls_wbase = '0; ls_we_cfg = 1'b0; ls_strb_cfg = '0;
        chk_b2b = 1'b0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        #1 reset = 1'b0;
        @(negedge clk);
        #1;

        // Single fetch
        exp_gnt.push_back(OWN_IF);
        issue_if(32'h0000_0100, 1);
        wait_idle("fetch");

        // Simultaneous store and fetch: store wins
        exp_gnt.push_back(OWN_LS);
        exp_gnt.push_back(OWN_IF);
        issue_ls(32'h0000_0200, 1, 1'b1, 32'h1234_5678, 4'hF);
        issue_if(32'h0000_0180, 1);
        wait_idle("both");

        // Starvation guard with back-to-back loads
        chk_b2b = 1'b1;
        for (int i = 0; i < 4; i++) exp_gnt.push_back(OWN_LS);
        exp_gnt.push_back(OWN_IF);
        exp_gnt.push_back(OWN_LS);
        exp_gnt.push_back(OWN_LS);
        exp_gnt.push_back(OWN_IF);
        issue_ls(32'h0000_0300, 6, 1'b0, '0, '0);
        issue_if(32'h0000_1000, 2);
        wait_idle("starve");
        chk_b2b = 1'b0;

        // Delayed memory grant, then a partial-strobe store
        gnt_delay = 3;
        exp_gnt.push_back(OWN_LS);
        issue_ls(32'h0000_0400, 1, 1'b0, '0, '0);
        wait_idle("slow_gnt");
        gnt_delay = 0;
        exp_gnt.push_back(OWN_LS);
        issue_ls(32'h0000_0440, 1, 1'b1, 32'hCAFE_0000, 4'h3);
        wait_idle("strb");

        // Spurious memory responses in IDLE and REQ
        spur_idle_tok++;
        repeat (3) @(negedge clk);
        #1;
        gnt_delay = 2;
        spur_req_tok++;
        exp_gnt.push_back(OWN_IF);
        issue_if(32'h0000_0800, 1);
        wait_idle("spurious");
        gnt_delay = 0;

        // Reset while waiting for the response
        rv_delay = 3;
        exp_gnt.push_back(OWN_LS);
        issue_ls(32'h0000_0500, 1, 1'b0, '0, '0);
        n = 0;
        while (n < 50 && !(mem_req && mem_gnt)) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_accept_seen", 64'(n < 50), 64'(1));
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk_quiet("abort");
        exp_rsp.delete();
        #1 reset = 1'b0;
        rv_delay = 1;
        repeat (4) @(negedge clk);
        #1;
        exp_gnt.push_back(OWN_IF);
        issue_if(32'h0000_0600, 1);
        n = 0;
        while (n < 20 && !if_req) begin
            @(negedge clk);
            n++;
        end
        check_eq("fresh_gnt", 64'(if_gnt), 64'(1));
        #2;
        wait_idle("after_abort");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

endmodule
